di_master: RTL and testbench
============================

Name: di_master

Overview:
- Device-interface (DI) initiator that drives diEpAddr/diRegAddr/diRead/diWrite/diRegDataIn and consumes diRegDataOut/rdwr_ready.
- It is the counterpart of a DI terminal. It executes one block read or block write command of cmd_len words against one endpoint/register, honouring the terminal's rdwr_ready flow control.
- Used on-FPGA for loopback/self-test of DI terminals and as a bus-functional master in simulation.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after address change before sampling rdwr_ready (the terminal's ready is registered and may be stale).
- RD_DEPTH, 4, read-return FIFO entries; power of 2, minimum 2.
- TIMEOUT_CYCLES, 1024, consecutive rdwr_ready-low cycles before abort (optional feature only).

Ports:
- if_clock  in  1  clock; all logic rising-edge.
- resetb  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = block write, 0 = block read.
- cmd_ep  in  16  target endpoint.
- cmd_reg  in  16  target register.
- cmd_len  in  16  word count; 0 = no-op.
- wr_data  in  16  write word.
- wr_valid  in  1  write word available.
- wr_ready  out  1  write word consumed this cycle.
- rd_data  out  16  read word (FIFO head).
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pops FIFO when rd_valid is high.
- diEpAddr  out  16  DI endpoint address.
- diRegAddr  out  16  DI register address.
- diRegDataIn  out  16  DI write data.
- diWrite  out  1  DI write strobe.
- diRead  out  1  DI read strobe.
- diReset  out  1  one-cycle terminal-context reset pulse.
- diRegDataOut  in  16  terminal read data.
- rdwr_ready  in  1  terminal ready (registered by the terminal).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- words_done  out  16  words transferred in the current or last command.

Behaviour:
- Reset (resetb=0 at an edge):
  - State goes to IDLE.
  - All DI outputs, wr_ready, done, busy and words_done go to 0.
  - FIFO is emptied and the in-flight count cleared.
  - Reset mid-transfer abandons the transfer with no done pulse.
- All DI outputs are registered.
- IDLE:
  - cmd_ready=1.
  - A cmd_valid accepted with cmd_len=0 pulses done the next cycle, clears words_done and stays in IDLE. No DI activity occurs.
  - Otherwise, on cmd_valid, latch ep/reg/len/write, clear words_done and go to SETUP.
- SETUP (1 cycle):
  - Drive diEpAddr/diRegAddr with the latched values.
  - Pulse diReset=1 for exactly this cycle.
  - Go to SETTLE.
- SETTLE:
  - Count SETTLE_CYCLES, ignoring rdwr_ready.
  - Then go to XFER.
- XFER, write:
  - wr_ready = rdwr_ready & wr_valid & (remaining>0). This output is combinational.
  - On accept: next cycle diWrite=1 and diRegDataIn=wr_data. Decrement remaining; increment words_done.
  - When remaining reaches 0, go to DONE.
- XFER, read:
  - Issue condition: rdwr_ready & (remaining>0) & (fifo_count+inflight < RD_DEPTH).
  - On issue: next cycle diRead=1; decrement remaining; inflight++.
  - When diRead is high in cycle C, capture diRegDataOut at the edge ending cycle C+1. Push it to the FIFO, inflight--, words_done++.
  - When remaining=0, go to DRAIN.
- DRAIN:
  - Wait until inflight=0, then go to DONE.
  - FIFO contents are retained; the consumer may pop after done.
- DONE (1 cycle):
  - done=1.
  - Return diEpAddr/diRegAddr to 0 and go to IDLE.
- Back-to-back strobes are allowed: one word per cycle while rdwr_ready stays high.
- diRead and diWrite are never both high.
- FIFO:
  - Simultaneous push and pop keeps the count.
  - Pop when empty is ignored.
  - The FIFO can never overflow, by construction of the issue condition.
- words_done wraps modulo 2^16. remaining is a 16-bit down-counter.
- cmd_valid while busy is ignored.

Optional Feature:
- Macro: DI_MASTER_TIMEOUT_EN.
- With the macro defined:
  - In XFER, a counter counts consecutive cycles with rdwr_ready=0 and clears on any high cycle.
  - At TIMEOUT_CYCLES the master stops issuing, then waits for inflight=0.
  - It then pulses done together with a one-cycle output timeout_err=1. This port exists only when the macro is defined.
  - words_done holds the partial count.
- Without the macro: the master waits indefinitely, and no timeout_err port exists.

Test Plan:
- Write, len=4, words A1..A4, rdwr_ready tied high:
  - diReset pulses once.
  - After 2 settle cycles, four consecutive diWrite cycles carry A1..A4.
  - done pulses with words_done=4.
- Read, len=8, terminal returns an incrementing counter from 0x10, rd_ready=1:
  - rd_data returns 0x10..0x17 in order.
  - diRead is never high without rdwr_ready having been high on the prior edge.
  - done follows the final capture.
- Read, len=8, rd_ready=0 until done is expected:
  - Exactly 4 diReads are issued, then issuing stalls.
  - Releasing rd_ready completes all 8 words with no loss or duplication.
- Write, len=3, rdwr_ready low for 20 cycles after settle, then high:
  - No diWrite and wr_ready=0 during the stall.
  - The 3 words are written afterwards.
- len=0: done pulses one cycle after acceptance, with no DI strobes and no diReset.
- Timeout, with DI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - Read len=5 with rdwr_ready held low after 2 words.
  - Result: timeout_err and done pulse together, and words_done=2.
- Reset mid-transfer: assert resetb=0 during XFER → all outputs 0 next cycle, FIFO empty, no done pulse.

Source files
------------

// File: rtl/di_master.sv
// DI initiator: runs one block read/write of cmd_len words against a DI terminal under rdwr_ready flow control.
// Optional: define DI_MASTER_TIMEOUT_EN to abort on a long rdwr_ready stall and report timeout_err.
module di_master #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RD_DEPTH      = 4
`ifdef DI_MASTER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic        if_clock,
  input  logic        resetb,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [15:0] cmd_ep,
  input  logic [15:0] cmd_reg,
  input  logic [15:0] cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [15:0] diEpAddr,
  output logic [15:0] diRegAddr,
  output logic [15:0] diRegDataIn,
  output logic        diWrite,
  output logic        diRead,
  output logic        diReset,
  input  logic [15:0] diRegDataOut,
  input  logic        rdwr_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_done
`ifdef DI_MASTER_TIMEOUT_EN
  ,
  output logic        timeout_err
`endif
);

  localparam int unsigned PTR_W = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RD_DEPTH + 1);
  localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`ifdef DI_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SETTLE, S_XFER, S_DRAIN, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        ep_q, ep_d, reg_q, reg_d;
  logic [15:0]        rem_q, rem_d, words_q, words_d, wdata_q, wdata_d;
  logic               write_q, write_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic               di_write_q, di_write_d, di_read_q, di_read_d, di_reset_q, di_reset_d;
  logic               done_q, done_d, busy_q, busy_d;
  logic               rd_pend_q;
  logic [CNT_W-1:0]   inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic [15:0]        mem_q [RD_DEPTH];
  logic               wr_accept, rd_issue, push, pop;
`ifdef DI_MASTER_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               to_flag_q, to_flag_d, to_err_q, to_err_d, to_hit;
`endif

  // A read issues only if its word is guaranteed a FIFO slot, so the FIFO cannot overflow.
  assign wr_accept = (state_q == S_XFER) && write_q && rdwr_ready && wr_valid && (rem_q != 16'd0);
  assign rd_issue  = (state_q == S_XFER) && !write_q && rdwr_ready && (rem_q != 16'd0) &&
                     (({1'b0, count_q} + {1'b0, inflight_q}) < (CNT_W + 1)'(RD_DEPTH));
  assign push      = rd_pend_q;
  assign pop       = rd_ready && (count_q != '0);

`ifdef DI_MASTER_TIMEOUT_EN
  assign to_hit      = (state_q == S_XFER) && !rdwr_ready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = to_err_q;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    ep_d       = ep_q;
    reg_d      = reg_q;
    rem_d      = rem_q;
    write_d    = write_q;
    settle_d   = settle_q;
    words_d    = words_q;
    wdata_d    = wdata_q;
    di_write_d = 1'b0;
    di_read_d  = 1'b0;
    di_reset_d = 1'b0;
    done_d     = 1'b0;
`ifdef DI_MASTER_TIMEOUT_EN
    to_cnt_d   = '0;
    to_flag_d  = to_flag_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          words_d = 16'd0;
          if (cmd_len == 16'd0) begin
            done_d = 1'b1;
          end else begin
            ep_d       = cmd_ep;
            reg_d      = cmd_reg;
            rem_d      = cmd_len;
            write_d    = cmd_write;
            di_reset_d = 1'b1;
            state_d    = S_SETUP;
`ifdef DI_MASTER_TIMEOUT_EN
            to_flag_d  = 1'b0;
`endif
          end
        end
      end
      S_SETUP: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? S_XFER : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_XFER;
        else settle_d = settle_q + SET_W'(1);
      end
      S_XFER: begin
        if (wr_accept) begin
          di_write_d = 1'b1;
          wdata_d    = wr_data;
          rem_d      = rem_q - 16'd1;
          words_d    = words_q + 16'd1;
          if (rem_q == 16'd1) state_d = S_DONE;
        end else if (rd_issue) begin
          di_read_d = 1'b1;
          rem_d     = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_DRAIN;
        end
`ifdef DI_MASTER_TIMEOUT_EN
        to_cnt_d = rdwr_ready ? '0 : to_cnt_q + TO_W'(1);
        if (to_hit) begin
          to_flag_d = 1'b1;
          state_d   = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        if (inflight_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        ep_d    = 16'd0;
        reg_d   = 16'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (push) words_d = words_d + 16'd1;
    done_d = done_d || (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
`ifdef DI_MASTER_TIMEOUT_EN
    to_err_d = (state_d == S_DONE) && to_flag_q;
`endif
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({rd_issue, push})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge if_clock) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      ep_q       <= 16'd0;
      reg_q      <= 16'd0;
      rem_q      <= 16'd0;
      write_q    <= 1'b0;
      settle_q   <= '0;
      words_q    <= 16'd0;
      wdata_q    <= 16'd0;
      di_write_q <= 1'b0;
      di_read_q  <= 1'b0;
      di_reset_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rd_pend_q  <= 1'b0;
      inflight_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
`ifdef DI_MASTER_TIMEOUT_EN
      to_cnt_q   <= '0;
      to_flag_q  <= 1'b0;
      to_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ep_q       <= ep_d;
      reg_q      <= reg_d;
      rem_q      <= rem_d;
      write_q    <= write_d;
      settle_q   <= settle_d;
      words_q    <= words_d;
      wdata_q    <= wdata_d;
      di_write_q <= di_write_d;
      di_read_q  <= di_read_d;
      di_reset_q <= di_reset_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rd_pend_q  <= di_read_q;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
`ifdef DI_MASTER_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      to_flag_q  <= to_flag_d;
      to_err_q   <= to_err_d;
`endif
    end
  end

  // Terminal data returns one cycle after the diRead strobe.
  always_ff @(posedge if_clock) begin
    if (push) mem_q[wptr_q] <= diRegDataOut;
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign wr_ready    = wr_accept;
  assign rd_valid    = (count_q != '0);
  assign rd_data     = rd_valid ? mem_q[rptr_q] : 16'd0;
  assign diEpAddr    = ep_q;
  assign diRegAddr   = reg_q;
  assign diRegDataIn = wdata_q;
  assign diWrite     = di_write_q;
  assign diRead      = di_read_q;
  assign diReset     = di_reset_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign words_done  = words_q;

endmodule

// File: tb/tb_di_master.sv
// Directed bench for di_master with a counting DI terminal model.
module tb_di_master;
  logic        if_clock, resetb;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_ep, cmd_reg, cmd_len;
  logic [15:0] wr_data, rd_data;
  logic        wr_valid, wr_ready, rd_valid, rd_ready;
  logic [15:0] diEpAddr, diRegAddr, diRegDataIn, diRegDataOut;
  logic        diWrite, diRead, diReset, rdwr_ready;
  logic        busy, done;
  logic [15:0] words_done;
`ifdef DI_MASTER_TIMEOUT_EN
  logic        timeout_err;
  localparam int STALL = 12;
`else
  localparam int STALL = 20;
`endif

  int errors = 0;
  int checks = 0;

  di_master #(
    .SETTLE_CYCLES(2),
    .RD_DEPTH(4)
`ifdef DI_MASTER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .if_clock(if_clock), .resetb(resetb),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_ep(cmd_ep), .cmd_reg(cmd_reg), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .diEpAddr(diEpAddr), .diRegAddr(diRegAddr), .diRegDataIn(diRegDataIn),
    .diWrite(diWrite), .diRead(diRead), .diReset(diReset),
    .diRegDataOut(diRegDataOut), .rdwr_ready(rdwr_ready),
    .busy(busy), .done(done), .words_done(words_done)
`ifdef DI_MASTER_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  initial if_clock = 1'b0;
  always #5 if_clock = ~if_clock;

  // Monitors, sampled mid-cycle.
  int n_wr = 0, n_rd = 0, n_rst = 0, n_done = 0, n_both = 0, n_rd_norrdy = 0;
  int n_to = 0, n_to_done = 0, cyc = 0, rst_cyc = 0, last_wd = 0;
  logic prev_rdy = 1'b0;
  logic [15:0] wq[$];
  logic [15:0] rq[$];
  int wcyc[$];

  always @(posedge if_clock) begin
    cyc <= cyc + 1;
    prev_rdy <= rdwr_ready;
  end

  always @(negedge if_clock) begin
    if (diWrite) begin n_wr++; wq.push_back(diRegDataIn); wcyc.push_back(cyc); end
    if (diRead) begin n_rd++; if (!prev_rdy) n_rd_norrdy++; end
    if (diRead && diWrite) n_both++;
    if (diReset) begin n_rst++; rst_cyc = cyc; end
    if (done) begin n_done++; last_wd = int'(words_done); end
    if (rd_valid && rd_ready) rq.push_back(rd_data);
`ifdef DI_MASTER_TIMEOUT_EN
    if (timeout_err) begin n_to++; if (done) n_to_done++; end
`endif
  end

  // Terminal model: each diRead yields the next counter value one cycle later.
  logic rd_flag = 1'b0;
  logic [15:0] term_cnt = 16'h0010;
  always @(negedge if_clock) rd_flag = diRead;
  always @(posedge if_clock) begin
    #1;
    if (rd_flag) begin diRegDataOut = term_cnt; term_cnt = term_cnt + 16'd1; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge if_clock);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [15:0] ep, input logic [15:0] rg, input logic [15:0] len);
    cmd_valid = 1'b1; cmd_write = wr; cmd_ep = ep; cmd_reg = rg; cmd_len = len;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    int d0 = n_done;
    while (n_done == d0 && c < budget) begin tick(); c++; end
    chk("done_seen", 32'(n_done - d0), 32'd1);
  endtask

  task automatic feed_writes(input int n, input logic [15:0] base, input int budget);
    int idx = 0;
    int c = 0;
    int d0 = n_done;
    logic acc;
    while (n_done == d0 && c < budget) begin
      wr_valid = (idx < n);
      wr_data  = base + 16'(idx);
      #1;
      acc = wr_ready;
      tick();
      if (acc) idx++;
      c++;
    end
    wr_valid = 1'b0;
    chk("wr_done_seen", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    int b, r0, w0, d0, stall_rdy;
    resetb = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_ep = '0; cmd_reg = '0; cmd_len = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; rdwr_ready = 1'b0; diRegDataOut = '0;
    tick(); tick();

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ep", 32'(diEpAddr), 32'd0);
    chk("rst_strobes", {29'd0, diWrite, diRead, diReset}, 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    resetb = 1'b1;
    tick();

    // Write len=4, A1..A4, rdwr_ready high
    rdwr_ready = 1'b1;
    b = wq.size(); r0 = n_rst;
    issue(1'b1, 16'h1234, 16'h0056, 16'd4);
    chk("w1_setup_reset", 32'(diReset), 32'd1);
    chk("w1_setup_ep", 32'(diEpAddr), 32'h1234);
    chk("w1_setup_reg", 32'(diRegAddr), 32'h0056);
    chk("w1_busy", 32'(busy), 32'd1);
    chk("w1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    feed_writes(4, 16'h00A1, 60);
    chk("w1_reset_pulses", 32'(n_rst - r0), 32'd1);
    chk("w1_nwords", 32'(wq.size() - b), 32'd4);
    for (int i = 0; i < 4; i++) chk("w1_data", 32'(wq[b + i]), 32'h00A1 + 32'(i));
    chk("w1_first_lat", 32'(wcyc[b] - rst_cyc), 32'd4);
    chk("w1_back2back", 32'(wcyc[b + 3] - wcyc[b]), 32'd3);
    chk("w1_words_done", 32'(last_wd), 32'd4);
    chk("w1_ep_cleared", 32'(diEpAddr), 32'd0);
    chk("w1_idle", 32'(busy), 32'd0);

    // Read len=8, rd_ready high, terminal counts from 0x10
    rd_ready = 1'b1;
    b = rq.size(); r0 = n_rd;
    issue(1'b0, 16'h0002, 16'h0007, 16'd8);
    wait_done(100);
    chk("r1_pops_at_done", 32'(rq.size() - b), 32'd8);
    for (int i = 0; i < 8; i++) chk("r1_data", 32'(rq[b + i]), 32'h0010 + 32'(i));
    chk("r1_nreads", 32'(n_rd - r0), 32'd8);
    chk("r1_words_done", 32'(last_wd), 32'd8);

    // Read len=8 with consumer stalled: issue stops at FIFO depth
    rd_ready = 1'b0;
    b = rq.size(); r0 = n_rd;
    issue(1'b0, 16'h0002, 16'h0008, 16'd8);
    for (int i = 0; i < 30; i++) tick();
    chk("r2_stalled_reads", 32'(n_rd - r0), 32'd4);
    chk("r2_rd_valid", 32'(rd_valid), 32'd1);
    chk("r2_busy", 32'(busy), 32'd1);
    rd_ready = 1'b1;
    wait_done(100);
    for (int i = 0; i < 6; i++) tick();
    chk("r2_npops", 32'(rq.size() - b), 32'd8);
    for (int i = 0; i < 8; i++) chk("r2_data", 32'(rq[b + i]), 32'h0018 + 32'(i));
    chk("r2_nreads", 32'(n_rd - r0), 32'd8);
    chk("r2_words_done", 32'(last_wd), 32'd8);
    chk("r2_fifo_empty", 32'(rd_valid), 32'd0);

    // Write len=3 with rdwr_ready low after settle
    rdwr_ready = 1'b0;
    b = wq.size(); w0 = n_wr; stall_rdy = 0;
    issue(1'b1, 16'h0003, 16'h0009, 16'd3);
    wr_valid = 1'b1; wr_data = 16'h00B1;
    tick(); tick();
    for (int i = 0; i < STALL; i++) begin #1; if (wr_ready) stall_rdy++; tick(); end
    chk("w2_stall_nowrite", 32'(n_wr - w0), 32'd0);
    chk("w2_stall_wr_ready", 32'(stall_rdy), 32'd0);
    chk("w2_stall_busy", 32'(busy), 32'd1);
    rdwr_ready = 1'b1;
    feed_writes(3, 16'h00B1, 60);
    chk("w2_nwords", 32'(wq.size() - b), 32'd3);
    for (int i = 0; i < 3; i++) chk("w2_data", 32'(wq[b + i]), 32'h00B1 + 32'(i));
    chk("w2_words_done", 32'(last_wd), 32'd3);

    // len=0 no-op
    r0 = n_rst; w0 = n_wr; d0 = n_rd;
    issue(1'b1, 16'h00FF, 16'h00FF, 16'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_words", 32'(words_done), 32'd0);
    chk("z_busy", 32'(busy), 32'd0);
    tick();
    chk("z_done_once", 32'(done), 32'd0);
    tick(); tick(); tick();
    chk("z_no_di", 32'((n_rst - r0) + (n_wr - w0) + (n_rd - d0)), 32'd0);

`ifdef DI_MASTER_TIMEOUT_EN
    // Timeout: read len=5, rdwr_ready dropped after two issues
    rdwr_ready = 1'b1; r0 = n_rd;
    issue(1'b0, 16'h0004, 16'h0001, 16'd5);
    tick(); tick(); tick(); tick(); tick();
    rdwr_ready = 1'b0;
    wait_done(100);
    chk("to_nreads", 32'(n_rd - r0), 32'd2);
    chk("to_words_done", 32'(last_wd), 32'd2);
    chk("to_err_pulses", 32'(n_to), 32'd1);
    chk("to_err_with_done", 32'(n_to_done), 32'd1);
    rdwr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
`endif

    // Reset mid-transfer
    rd_ready = 1'b0; rdwr_ready = 1'b1;
    issue(1'b0, 16'h0005, 16'h0006, 16'd8);
    for (int i = 0; i < 6; i++) tick();
    chk("mr_in_xfer", 32'(busy), 32'd1);
    d0 = n_done;
    resetb = 1'b0;
    tick();
    chk("mr_strobes", {29'd0, diWrite, diRead, diReset}, 32'd0);
    chk("mr_addr", {diEpAddr, diRegAddr}, 32'd0);
    chk("mr_busy_done", {30'd0, busy, done}, 32'd0);
    chk("mr_words", 32'(words_done), 32'd0);
    chk("mr_fifo", {15'd0, rd_valid, rd_data}, 32'd0);
    chk("mr_wr_ready", 32'(wr_ready), 32'd0);
    resetb = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_no_done", 32'(n_done - d0), 32'd0);

    // Global invariants
    chk("never_both_strobes", 32'(n_both), 32'd0);
    chk("read_needs_ready", 32'(n_rd_norrdy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
